// File: rtl/wbs_pkg.sv
// Shared constants and types for the wishbone slave controller:
// the user address map and the slave FSM state encoding.
package wbs_pkg;

  localparam logic [31:0] WBS_ADDR_MASK      = 32'hFFFF_0000;

  localparam logic [31:0] WBS_MODE_ADDR      = 32'h3000_0000;
  localparam logic [31:0] WBS_DEBUG_ADDR     = 32'h3000_0004;
  localparam logic [31:0] WBS_DONE_ADDR      = 32'h3000_0008;
  localparam logic [31:0] WBS_FSM_START_ADDR = 32'h3000_000C;
  localparam logic [31:0] WBS_FSM_BUSY_ADDR  = 32'h3000_0010;

  localparam logic [31:0] WBS_QUERY_ADDR     = 32'h3001_0000;
  localparam logic [31:0] WBS_LEAF_ADDR      = 32'h3002_0000;
  localparam logic [31:0] WBS_BEST_ADDR      = 32'h3003_0000;
  localparam logic [31:0] WBS_NODE_ADDR      = 32'h3004_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ACK     = 2'd2
  } wbs_state_e;

  // Which 64-bit window a staged pair write lands in.
  typedef enum logic {
    WIN_QUERY = 1'b0,
    WIN_LEAF  = 1'b1
  } pair_win_e;

endpackage

// File: rtl/wbs_slave_ctrl_if.sv
// Wishbone classic slave bus bundle (handshake, address and data).
interface wbs_slave_ctrl_if;

  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/wbs_pair_stager.sv
// Builds 64-bit words from two 32-bit beats. The lower beat is held in
// stage_lo; the upper beat fires a one-cycle write into the selected
// window (query or leaf) and empties the stage. One stage is shared by
// both windows.
module wbs_pair_stager
  import wbs_pkg::*;
#(
  parameter int ROW_WIDTH = 12
) (
  input  logic                 wb_clk_i,
  input  logic                 rst_n,
  input  logic                 beat_valid,
  input  logic                 upper,
  input  pair_win_e            win_sel,
  input  logic [ROW_WIDTH-1:0] row,
  input  logic [31:0]          beat_data,
  output logic                 query_wen,
  output logic                 leaf_wen,
  output logic [ROW_WIDTH-1:0] row_q,
  output logic [63:0]          word_q
);

  logic [31:0] stage_lo;

  // Latch lower beats, emit a single write pulse on each upper beat.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stage_lo  <= '0;
      query_wen <= 1'b0;
      leaf_wen  <= 1'b0;
      row_q     <= '0;
      word_q    <= '0;
    end else begin
      query_wen <= 1'b0;
      leaf_wen  <= 1'b0;
      if (beat_valid) begin
        if (!upper) begin
          stage_lo <= beat_data;
        end else begin
          word_q   <= {beat_data, stage_lo};
          row_q    <= row;
          stage_lo <= '0;
          if (win_sel == WIN_LEAF) leaf_wen  <= 1'b1;
          else                     query_wen <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wbs_slave_ctrl.sv
// Wishbone classic slave for the KD-tree user project: control/status
// registers plus query, leaf, best and node memory windows. Every
// request gets exactly one ack; best reads take one extra cycle for the
// SRAM, everything else is acked the cycle after the request.
module wbs_slave_ctrl
  import wbs_pkg::*;
#(
  parameter int DATA_WIDTH       = 11,
  parameter int LEAF_ADDR_WIDTH  = 12,
  parameter int QUERY_ADDR_WIDTH = 12,
  parameter int NODE_ADDR_WIDTH  = 6,
  parameter int BEST_ADDR_WIDTH  = 10
) (
  input  logic                        wb_clk_i,
  input  logic                        rst_n,
  wbs_slave_ctrl_if.slave             wbs,
  output logic                        mode,
  output logic                        debug,
  output logic                        fsm_start,
  input  logic                        fsm_done,
  input  logic                        fsm_busy,
  output logic                        query_wen,
  output logic [QUERY_ADDR_WIDTH-1:0] query_waddr,
  output logic [5*DATA_WIDTH-1:0]     query_wdata,
  output logic                        leaf_wen,
  output logic [LEAF_ADDR_WIDTH-1:0]  leaf_waddr,
  output logic [63:0]                 leaf_wdata,
  output logic                        node_wen,
  output logic [NODE_ADDR_WIDTH-1:0]  node_waddr,
  output logic [2*DATA_WIDTH-1:0]     node_wdata,
  output logic                        best_ren,
  output logic [BEST_ADDR_WIDTH-1:0]  best_raddr,
  input  logic [31:0]                 best_rdata
);

  localparam int PAIR_ROW_W = (LEAF_ADDR_WIDTH > QUERY_ADDR_WIDTH) ?
                              LEAF_ADDR_WIDTH : QUERY_ADDR_WIDTH;

  wbs_state_e             state;
  logic                   ack_q;
  logic                   rd_best_q;
  logic [31:0]            rd_data_q;
  logic                   done_sticky;
  logic [31:0]            region;
  logic                   req_idle;
  logic                   is_query;
  logic                   is_leaf;
  logic                   pair_beat;
  logic [PAIR_ROW_W-1:0]  pair_row;
  logic [PAIR_ROW_W-1:0]  pair_row_q;
  logic [63:0]            pair_word_q;
  logic [31:0]            rd_mux;

  assign region    = wbs.wbs_adr_i & WBS_ADDR_MASK;
  assign req_idle  = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_q && (state == ST_IDLE);
  assign is_query  = (region == WBS_QUERY_ADDR);
  assign is_leaf   = (region == WBS_LEAF_ADDR);
  assign pair_beat = req_idle && wbs.wbs_we_i && (is_query || is_leaf);
  assign pair_row  = is_leaf ? PAIR_ROW_W'(wbs.wbs_adr_i[LEAF_ADDR_WIDTH+2:3])
                             : PAIR_ROW_W'(wbs.wbs_adr_i[QUERY_ADDR_WIDTH+2:3]);

  wbs_pair_stager #(
    .ROW_WIDTH (PAIR_ROW_W)
  ) u_stager (
    .wb_clk_i  (wb_clk_i),
    .rst_n     (rst_n),
    .beat_valid(pair_beat),
    .upper     (wbs.wbs_adr_i[2]),
    .win_sel   (is_leaf ? WIN_LEAF : WIN_QUERY),
    .row       (pair_row),
    .beat_data (wbs.wbs_dat_i),
    .query_wen (query_wen),
    .leaf_wen  (leaf_wen),
    .row_q     (pair_row_q),
    .word_q    (pair_word_q)
  );

  assign query_waddr = pair_row_q[QUERY_ADDR_WIDTH-1:0];
  assign query_wdata = pair_word_q[5*DATA_WIDTH-1:0];
  assign leaf_waddr  = pair_row_q[LEAF_ADDR_WIDTH-1:0];
  assign leaf_wdata  = pair_word_q;

  // Register-file read value; anything not a listed register reads 0.
  always_comb begin
    rd_mux = '0;
    case (wbs.wbs_adr_i)
      WBS_MODE_ADDR:     rd_mux = {31'b0, mode};
      WBS_DEBUG_ADDR:    rd_mux = {31'b0, debug};
      WBS_DONE_ADDR:     rd_mux = {31'b0, done_sticky};
      WBS_FSM_BUSY_ADDR: rd_mux = {31'b0, fsm_busy};
      default:           rd_mux = '0;
    endcase
  end

  // Best-read data comes straight from the SRAM in its ack cycle.
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = !ack_q ? 32'h0 : (rd_best_q ? best_rdata : rd_data_q);

  // Slave FSM with registers, done_sticky and the node/best ports.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ack_q       <= 1'b0;
      rd_best_q   <= 1'b0;
      rd_data_q   <= '0;
      mode        <= 1'b0;
      debug       <= 1'b0;
      fsm_start   <= 1'b0;
      done_sticky <= 1'b0;
      node_wen    <= 1'b0;
      node_waddr  <= '0;
      node_wdata  <= '0;
      best_ren    <= 1'b0;
      best_raddr  <= '0;
    end else begin
      fsm_start <= 1'b0;
      node_wen  <= 1'b0;
      best_ren  <= 1'b0;
      if (fsm_done)       done_sticky <= 1'b1;
      else if (fsm_start) done_sticky <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req_idle) begin
            if ((region == WBS_BEST_ADDR) && !wbs.wbs_we_i) begin
              state      <= ST_RD_WAIT;
              best_ren   <= 1'b1;
              best_raddr <= wbs.wbs_adr_i[BEST_ADDR_WIDTH+1:2];
            end else begin
              state     <= ST_ACK;
              ack_q     <= 1'b1;
              rd_best_q <= 1'b0;
              rd_data_q <= wbs.wbs_we_i ? 32'h0 : rd_mux;
              if (wbs.wbs_we_i) begin
                case (wbs.wbs_adr_i)
                  WBS_MODE_ADDR:      mode      <= wbs.wbs_dat_i[0];
                  WBS_DEBUG_ADDR:     debug     <= wbs.wbs_dat_i[0];
                  WBS_DONE_ADDR:      if (!fsm_done) done_sticky <= 1'b0;
                  WBS_FSM_START_ADDR: fsm_start <= 1'b1;
                  default: ;
                endcase
                if (region == WBS_NODE_ADDR) begin
                  node_wen   <= 1'b1;
                  node_waddr <= wbs.wbs_adr_i[NODE_ADDR_WIDTH-1:0];
                  node_wdata <= wbs.wbs_dat_i[2*DATA_WIDTH-1:0];
                end
              end
            end
          end
        end
        ST_RD_WAIT: begin
          if (!wbs.wbs_cyc_i) begin
            state <= ST_IDLE;
          end else begin
            state     <= ST_ACK;
            ack_q     <= 1'b1;
            rd_best_q <= 1'b1;
          end
        end
        ST_ACK: begin
          state     <= ST_IDLE;
          ack_q     <= 1'b0;
          rd_best_q <= 1'b0;
          rd_data_q <= '0;
        end
        default: begin
          state <= ST_IDLE;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbs_slave_ctrl.sv
// Bench for wbs_slave_ctrl: directed steps followed by randomized bus
// traffic, compared against a transaction-level model of the address map.
module tb_wbs_slave_ctrl;

  localparam int DW  = 11;
  localparam int LAW = 12;
  localparam int QAW = 12;
  localparam int NAW = 6;
  localparam int BAW = 10;

  logic              wb_clk_i = 1'b0;
  logic              rst_n    = 1'b0;
  logic              mode, debug, fsm_start;
  logic              fsm_done = 1'b0;
  logic              fsm_busy = 1'b0;
  logic              query_wen;
  logic [QAW-1:0]    query_waddr;
  logic [5*DW-1:0]   query_wdata;
  logic              leaf_wen;
  logic [LAW-1:0]    leaf_waddr;
  logic [63:0]       leaf_wdata;
  logic              node_wen;
  logic [NAW-1:0]    node_waddr;
  logic [2*DW-1:0]   node_wdata;
  logic              best_ren;
  logic [BAW-1:0]    best_raddr;
  logic [31:0]       best_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  wbs_slave_ctrl_if bus ();

  wbs_slave_ctrl #(
    .DATA_WIDTH      (DW),
    .LEAF_ADDR_WIDTH (LAW),
    .QUERY_ADDR_WIDTH(QAW),
    .NODE_ADDR_WIDTH (NAW),
    .BEST_ADDR_WIDTH (BAW)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .rst_n      (rst_n),
    .wbs        (bus),
    .mode       (mode),
    .debug      (debug),
    .fsm_start  (fsm_start),
    .fsm_done   (fsm_done),
    .fsm_busy   (fsm_busy),
    .query_wen  (query_wen),
    .query_waddr(query_waddr),
    .query_wdata(query_wdata),
    .leaf_wen   (leaf_wen),
    .leaf_waddr (leaf_waddr),
    .leaf_wdata (leaf_wdata),
    .node_wen   (node_wen),
    .node_waddr (node_waddr),
    .node_wdata (node_wdata),
    .best_ren   (best_ren),
    .best_raddr (best_raddr),
    .best_rdata (best_rdata)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Best SRAM stand-in: word w holds 0xDEAD0000 + w, one cycle latency.
  always @(posedge wb_clk_i) begin
    if (best_ren) best_rdata <= 32'hDEAD_0000 + 32'(best_raddr);
  end

  // Pulse counters and last-seen write port values.
  int          leaf_cnt = 0, query_cnt = 0, node_cnt = 0, start_cnt = 0;
  logic [63:0] leaf_last_data = '0, query_last_data = '0, node_last_data = '0;
  logic [31:0] leaf_last_row = '0, query_last_row = '0, node_last_idx = '0;

  always @(negedge wb_clk_i) begin
    if (leaf_wen)  begin leaf_cnt++;  leaf_last_row  = 32'(leaf_waddr);  leaf_last_data  = leaf_wdata;         end
    if (query_wen) begin query_cnt++; query_last_row = 32'(query_waddr); query_last_data = 64'(query_wdata); end
    if (node_wen)  begin node_cnt++;  node_last_idx  = 32'(node_waddr);  node_last_data  = 64'(node_wdata);  end
    if (fsm_start) start_cnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  // Transaction-level reference model of the slave.
  logic        m_mode = 1'b0, m_debug = 1'b0, m_done = 1'b0;
  logic [31:0] m_stage = '0;
  int          m_leaf_cnt = 0, m_query_cnt = 0, m_node_cnt = 0, m_start_cnt = 0;
  logic [63:0] m_leaf_data = '0, m_query_data = '0, m_node_data = '0;
  logic [31:0] m_leaf_row = '0, m_query_row = '0, m_node_idx = '0;

  function automatic logic [31:0] modelRead(input logic [31:0] addr);
    logic [31:0] off;
    off = addr % 32'h1_0000;
    if (addr == 32'h3000_0000) return {31'b0, m_mode};
    if (addr == 32'h3000_0004) return {31'b0, m_debug};
    if (addr == 32'h3000_0008) return {31'b0, m_done};
    if (addr == 32'h3000_0010) return {31'b0, fsm_busy};
    if (addr / 32'h1_0000 == 32'h3003) return 32'hDEAD_0000 + (off / 4) % 1024;
    return 32'h0;
  endfunction

  function automatic void modelWrite(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] off;
    logic [31:0] reg_hi;
    logic [63:0] word;
    off    = addr % 32'h1_0000;
    reg_hi = addr / 32'h1_0000;
    word   = 64'(data) * 64'h1_0000_0000 + 64'(m_stage);
    if (addr == 32'h3000_0000) m_mode = data[0];
    else if (addr == 32'h3000_0004) m_debug = data[0];
    else if (addr == 32'h3000_0008) m_done = 1'b0;
    else if (addr == 32'h3000_000C) begin m_start_cnt++; m_done = 1'b0; end
    else if (reg_hi == 32'h3001 || reg_hi == 32'h3002) begin
      if ((off / 4) % 2 == 0) m_stage = data;
      else begin
        if (reg_hi == 32'h3002) begin
          m_leaf_cnt++; m_leaf_row = (off / 8) % 4096; m_leaf_data = word;
        end else begin
          m_query_cnt++; m_query_row = (off / 8) % 4096; m_query_data = word % (64'd1 << 55);
        end
        m_stage = 32'h0;
      end
    end else if (reg_hi == 32'h3004) begin
      m_node_cnt++; m_node_idx = off % 64; m_node_data = 64'(data) % (64'd1 << 22);
    end
  endfunction

  logic       ren_at_lat1;
  logic [3:0] wen_at_ack;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One bus access; returns read data and ack latency in cycles.
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] data,
                               output logic [31:0] rdata, output int lat);
    bus.wbs_adr_i = addr;
    bus.wbs_we_i  = we;
    bus.wbs_dat_i = data;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    lat = 0;
    ren_at_lat1 = 1'b0;
    while (lat < 6) begin
      @(negedge wb_clk_i);
      lat++;
      if (lat == 1) ren_at_lat1 = best_ren;
      if (bus.wbs_ack_o) break;
    end
    rdata = bus.wbs_dat_o;
    wen_at_ack = {query_wen, leaf_wen, node_wen, fsm_start};
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    @(negedge wb_clk_i);
    checkOutput("ack_single_cycle", 64'(bus.wbs_ack_o), 64'd0);
    checkOutput("dat_zero_no_ack", 64'(bus.wbs_dat_o), 64'd0);
  endtask

  task automatic applyWrite(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    int lat;
    applyStimulus(addr, 1'b1, data, rd, lat);
    checkOutput("write_ack_latency", 64'(lat), 64'd1);
    modelWrite(addr, data);
  endtask

  task automatic applyRead(input logic [31:0] addr, input string tag);
    logic [31:0] rd;
    int lat;
    int exp_lat;
    exp_lat = (addr / 32'h1_0000 == 32'h3003) ? 2 : 1;
    applyStimulus(addr, 1'b0, 32'h0, rd, lat);
    checkOutput("read_ack_latency", 64'(lat), 64'(exp_lat));
    checkOutput(tag, 64'(rd), 64'(modelRead(addr)));
  endtask

  task automatic compareState();
    checkOutput("mode_pin", 64'(mode), 64'(m_mode));
    checkOutput("debug_pin", 64'(debug), 64'(m_debug));
    checkOutput("leaf_wen_count", 64'(leaf_cnt), 64'(m_leaf_cnt));
    checkOutput("query_wen_count", 64'(query_cnt), 64'(m_query_cnt));
    checkOutput("node_wen_count", 64'(node_cnt), 64'(m_node_cnt));
    checkOutput("start_pulse_count", 64'(start_cnt), 64'(m_start_cnt));
    if (m_leaf_cnt > 0) begin
      checkOutput("leaf_waddr", 64'(leaf_last_row), 64'(m_leaf_row));
      checkOutput("leaf_wdata", leaf_last_data, m_leaf_data);
    end
    if (m_query_cnt > 0) begin
      checkOutput("query_waddr", 64'(query_last_row), 64'(m_query_row));
      checkOutput("query_wdata", query_last_data, m_query_data);
    end
    if (m_node_cnt > 0) begin
      checkOutput("node_waddr", 64'(node_last_idx), 64'(m_node_idx));
      checkOutput("node_wdata", node_last_data, m_node_data);
    end
  endtask

  task automatic pulseDone();
    fsm_done = 1'b1;
    @(negedge wb_clk_i);
    fsm_done = 1'b0;
    m_done = 1'b1;
    @(negedge wb_clk_i);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] addr, data;
    int lat, hits, first_ack, second_ack, op;

    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;

    #1;
    checkOutput("reset_ack", 64'(bus.wbs_ack_o), 64'd0);
    checkOutput("reset_dat", 64'(bus.wbs_dat_o), 64'd0);
    checkOutput("reset_mode_debug", {62'd0, mode, debug}, 64'd0);
    checkOutput("reset_pulses", {59'd0, fsm_start, leaf_wen, query_wen, node_wen, best_ren}, 64'd0);
    repeat (3) @(negedge wb_clk_i);
    rst_n = 1'b1;
    @(negedge wb_clk_i);

    // Debug register write and readback.
    applyWrite(32'h3000_0004, 32'h1);
    compareState();
    applyRead(32'h3000_0004, "debug_readback");

    // Leaf pair write: lower beat stages, upper beat writes.
    applyWrite(32'h3002_0018, 32'h89AB_CDEF);
    checkOutput("leaf_lower_no_wen", 64'(wen_at_ack[2]), 64'd0);
    compareState();
    applyWrite(32'h3002_001C, 32'h0123_4567);
    checkOutput("leaf_upper_wen_at_ack", 64'(wen_at_ack[2]), 64'd1);
    checkOutput("leaf_pair_data", leaf_last_data, 64'h0123_4567_89AB_CDEF);
    checkOutput("leaf_pair_row", 64'(leaf_last_row), 64'd3);
    compareState();

    // Node write with stb held across two beats.
    bus.wbs_adr_i = 32'h3004_0005; bus.wbs_dat_i = 32'h0001_B801; bus.wbs_we_i = 1'b1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    hits = 0; first_ack = 0; second_ack = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge wb_clk_i);
      if (bus.wbs_ack_o) begin
        hits++;
        if (hits == 1) first_ack = i;
        else begin second_ack = i; break; end
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    @(negedge wb_clk_i);
    modelWrite(32'h3004_0005, 32'h0001_B801);
    modelWrite(32'h3004_0005, 32'h0001_B801);
    checkOutput("node_held_ack_count", 64'(hits), 64'd2);
    checkOutput("node_first_ack_latency", 64'(first_ack), 64'd1);
    checkOutput("node_ack_gap_ok", 64'(second_ack - first_ack >= 2), 64'd1);
    checkOutput("node_wdata_value", node_last_data, 64'h01B801);
    compareState();

    // Best read: ren in k+1, data and ack in k+2.
    applyStimulus(32'h3003_0010, 1'b0, 32'h0, rd, lat);
    checkOutput("best_ren_k1", 64'(ren_at_lat1), 64'd1);
    checkOutput("best_raddr", 64'(best_raddr), 64'd4);
    checkOutput("best_ack_latency", 64'(lat), 64'd2);
    checkOutput("best_rdata", 64'(rd), 64'hDEAD_0004);

    // Control flow: start pulse, done sticky set and cleared.
    applyWrite(32'h3000_000C, 32'h1);
    checkOutput("start_at_ack", 64'(wen_at_ack[0]), 64'd1);
    compareState();
    pulseDone();
    applyRead(32'h3000_0008, "done_after_pulse");
    applyWrite(32'h3000_0008, 32'h0);
    applyRead(32'h3000_0008, "done_after_clear");
    pulseDone();
    applyWrite(32'h3000_000C, 32'h1);
    applyRead(32'h3000_0008, "done_cleared_by_start");

    // Unmapped accesses still ack, return 0, write nothing.
    applyWrite(32'h3005_0000, 32'hFFFF_FFFF);
    compareState();
    applyRead(32'h3005_0000, "unmapped_read");
    applyRead(32'h3000_0014, "unmapped_reg_read");

    // cyc dropped while waiting on the best SRAM: no ack.
    bus.wbs_adr_i = 32'h3003_0008; bus.wbs_we_i = 1'b0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    @(negedge wb_clk_i);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      if (bus.wbs_ack_o) hits++;
    end
    checkOutput("cyc_drop_no_ack", 64'(hits), 64'd0);
    applyRead(32'h3003_0008, "best_after_cyc_drop");

    // Async reset in the middle of a best read.
    applyWrite(32'h3000_0000, 32'h1);
    applyWrite(32'h3000_0004, 32'h1);
    applyWrite(32'h3002_0038, 32'h1111_2222);
    bus.wbs_adr_i = 32'h3003_0020; bus.wbs_we_i = 1'b0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    @(negedge wb_clk_i);
    checkOutput("rdwait_best_ren", 64'(best_ren), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_ack", 64'(bus.wbs_ack_o), 64'd0);
    checkOutput("reset_mid_mode_debug", {62'd0, mode, debug}, 64'd0);
    checkOutput("reset_mid_best_ren", 64'(best_ren), 64'd0);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(negedge wb_clk_i);
    rst_n = 1'b1;
    m_mode = 1'b0; m_debug = 1'b0; m_done = 1'b0; m_stage = 32'h0;
    @(negedge wb_clk_i);
    applyWrite(32'h3002_003C, 32'h3333_4444);
    checkOutput("stage_lost_on_reset", leaf_last_data, 64'h3333_4444_0000_0000);
    compareState();

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      fsm_busy = 1'($urandom_range(0, 1));
      op   = $urandom_range(0, 9);
      data = $urandom;
      case (op)
        0: applyWrite(32'h3000_0000, data);
        1: applyWrite(32'h3000_0004, data);
        2: begin
          case ($urandom_range(0, 5))
            0: addr = 32'h3000_0000;
            1: addr = 32'h3000_0004;
            2: addr = 32'h3000_0008;
            3: addr = 32'h3000_000C;
            4: addr = 32'h3000_0010;
            default: addr = 32'h3000_0020;
          endcase
          applyRead(addr, "rand_reg_read");
        end
        3, 4: applyWrite(32'h3002_0000 + 8 * $urandom_range(0, 4095) + ((op == 4) ? 4 : 0), data);
        5, 6: applyWrite(32'h3001_0000 + 8 * $urandom_range(0, 4095) + ((op == 6) ? 4 : 0), data);
        7: applyWrite(32'h3004_0000 + $urandom_range(0, 63), data);
        8: begin
          addr = 32'h3003_0000 + 4 * $urandom_range(0, 1023);
          if (data[0]) applyWrite(addr, data);
          else applyRead(addr, "rand_best_read");
        end
        default: begin
          addr = 32'h3005_0000 + 32'h1_0000 * $urandom_range(0, 200) + $urandom_range(0, 65535);
          if (data[0]) applyWrite(addr, data);
          else applyRead(addr, "rand_unmapped_read");
        end
      endcase
      compareState();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wbs_slave_ctrl.md
Name: wbs_slave_ctrl

Overview:
- Wishbone classic slave that terminates the bus transactions of the management SoC (or bench) inside user_proj_example.
- Decodes the user address map into control/status registers and four memory windows: query, leaf, best, node.
- Assembles the 64-bit leaf and query writes from pairs of 32-bit beats, and serves best-array reads with SRAM latency.
- Sits between the wishbone pins and the KD-tree SRAM wrappers / top FSM.

Parameters:
- DATA_WIDTH, 11, width of one patch element / node field.
- LEAF_ADDR_WIDTH, 12, leaf SRAM row index width (64 leaves x 48 rows).
- QUERY_ADDR_WIDTH, 12, query SRAM row index width.
- NODE_ADDR_WIDTH, 6, internal-node index width.
- BEST_ADDR_WIDTH, 10, best-array word index width.

Ports:
- wb_clk_i  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  cycle valid.
- wbs_we_i  in  1  1=write.
- wbs_sel_i  in  4  byte selects; ignored, every access is full-word.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- mode  out  1  mode register bit0.
- debug  out  1  debug register bit0.
- fsm_start  out  1  one-cycle start pulse.
- fsm_done  in  1  done pulse from top FSM.
- fsm_busy  in  1  busy level from top FSM.
- query_wen / query_waddr / query_wdata  out  1 / QUERY_ADDR_WIDTH / 5*DATA_WIDTH  query SRAM write port.
- leaf_wen / leaf_waddr / leaf_wdata  out  1 / LEAF_ADDR_WIDTH / 64  leaf SRAM write port.
- node_wen / node_waddr / node_wdata  out  1 / NODE_ADDR_WIDTH / 2*DATA_WIDTH  node write port.
- best_ren / best_raddr  out  1 / BEST_ADDR_WIDTH  best SRAM read port.
- best_rdata  in  32  read data, valid one cycle after best_ren.

Behaviour:
- Reset: all outputs 0, internal staging registers 0, FSM in IDLE, done_sticky 0.
- Request: sampled at a posedge when cyc & stb & ~wbs_ack_o. Region selected by adr & 32'hFFFF_0000.
- Registers:
  - 0x3000_0000 mode: RW bit0.
  - 0x3000_0004 debug: RW bit0.
  - 0x3000_0008 done: R returns {31'b0, done_sticky}; a write clears it.
  - 0x3000_000C fsm_start: a write produces a one-cycle fsm_start pulse; reads return 0.
  - 0x3000_0010 busy: R returns {31'b0, fsm_busy}.
- done_sticky: set on fsm_done and cleared by fsm_start. If both occur in the same cycle, set wins.
- Windows:
  - query 0x3001_xxxx: row = adr[QUERY_ADDR_WIDTH+2:3].
  - leaf 0x3002_xxxx: row = adr[LEAF_ADDR_WIDTH+2:3].
  - best 0x3003_xxxx: word = adr[BEST_ADDR_WIDTH+1:2].
  - node 0x3004_xxxx: byte-granular, index = adr[NODE_ADDR_WIDTH-1:0].
- Leaf/query pair writes:
  - adr[2]=0 (lower beat): latch wbs_dat_i into stage_lo; no SRAM write.
  - adr[2]=1 (upper beat): single-cycle wen with wdata = {wbs_dat_i, stage_lo}, truncated to port width; waddr taken from the upper beat's address. stage_lo clears to 0 after the write.
  - Upper beat without a prior lower: written with lower=0.
  - Two consecutive lower beats: the last one wins.
- Node write: node_wdata = wbs_dat_i[21:0] ({median, index}), node_wen for one cycle.
- Write latency: request seen at edge k -> wbs_ack_o=1 and the memory/register write during cycle k+1.
- Control-register read: ack and wbs_dat_o during cycle k+1.
- Best read:
  - best_ren = 1 in cycle k+1 with best_raddr.
  - Cycle k+2: wbs_dat_o = best_rdata, ack.
  - Writes to the best window are acked and ignored.
- FSM states:
  - IDLE: on a best read -> RD_WAIT; any other request -> ACK.
  - RD_WAIT -> ACK.
  - ACK -> IDLE.
- Ack: exactly one cycle per request. A stb held high across beats is re-sampled at the first edge after ack drops, so back-to-back beats are separated by at least one cycle.
- wbs_dat_o is 0 whenever ack=0.
- Unmapped address (any region or register offset not listed): ack in k+1, read data 0, write ignored. The bus never hangs.
- cyc drop in RD_WAIT: return to IDLE with no ack. The SRAM read is harmless.
- Async reset mid-transaction: immediate return to IDLE, ack 0, staging lost.

Decomposition:
- Shared package wbs_pkg:
  - Address constants: WBS_ADDR_MASK, WBS_MODE_ADDR, WBS_DEBUG_ADDR, WBS_DONE_ADDR, WBS_FSM_START_ADDR, WBS_FSM_BUSY_ADDR, WBS_QUERY_ADDR, WBS_LEAF_ADDR, WBS_BEST_ADDR, WBS_NODE_ADDR.
  - Enum typedef for the slave FSM state.
- One sub-module, wbs_pair_stager: holds the lower-beat latch and emits the 64-bit word plus write enable. Instantiated once, shared by the query and leaf windows, with a window-select input.

Test Plan:
- Write 1 to 0x3000_0004, then read it back -> debug=1; ack high exactly 1 cycle per access, one cycle after stb; readback data 0x1.
- Leaf pair:
  - Stimulus: lower beat 0x89ABCDEF at 0x3002_0018, then upper beat 0x01234567 at 0x3002_001C.
  - Response: a single leaf_wen pulse on the upper ack, leaf_waddr=3, leaf_wdata=0x0123456789ABCDEF; no wen on the lower beat.
- Node write {median 55, index 1} = 0x0001B801 at 0x3004_0005 with stb held across two beats -> node_waddr=5, node_wdata=22'h01B801, two acks separated by at least one idle cycle.
- Best read at 0x3003_0010 with best_rdata model returning 0xDEAD0004 -> best_ren in k+1 with raddr=4; ack and wbs_dat_o=0xDEAD0004 in k+2.
- Control flow:
  - Write 0x3000_000C -> fsm_start high for 1 cycle.
  - Pulse fsm_done, then read 0x3000_0008 -> 0x1.
  - Write 0x3000_0008, then read it -> 0x0.
- Unmapped and reset cases:
  - Write/read at 0x3005_0000 -> ack in 1 cycle, data 0, no wen.
  - Assert rst_n=0 during RD_WAIT -> ack 0 immediately, state IDLE, mode/debug 0.
